// File: rtl/signal_capture.sv
// Triggered pin sampler: captures up to 64 samples at the divided tick rate and commits them to the register bank.
// Latency: with bypass, len samples at T+1..T+len after the accept cycle T, one-cycle COMMIT at T+len+1.
// Backpressure: none; edges outside IDLE are dropped. SIGNAL_CAPTURE_TIMESTAMP_EN adds counter timestamp writes.
module signal_capture #(
    parameter int RW_REG_COUNT           = 22,
    parameter int CAP_DATA_REGISTER      = 0,
    parameter int CAP_TIMESTAMP_REGISTER = 8,
    parameter int CAP_LENGTH_REGISTER    = 17,
    parameter int CAP_CONFIG_REGISTER    = 20,
    parameter int CAP_COUNT_REGISTER     = 21
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sig_in,
    input  logic                      trigger,
    input  logic                      clk_div,
    input  logic                      is_div_bypass,
    input  logic [31:0]               counter,
    input  logic [1:0]                loop_mode,
    input  logic                      is_trigger_on_rising_edge,
    input  logic                      is_trigger_on_falling_edge,
    input  logic [RW_REG_COUNT*8-1:0] was_config,
    output logic [RW_REG_COUNT*8-1:0] is_config,
    output logic [RW_REG_COUNT-1:0]   is_update_flag,
    output logic                      is_running,
    output logic                      is_done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        prev_trigger;
    logic        prev_clk_div;
    logic [63:0] buffer;
    logic [5:0]  remaining;

    logic        tick;
    logic        trig_edge;
    logic        accept;
    logic        restart;
    logic        reload;
    logic [5:0]  len_field;

    assign tick      = (clk_div & ~prev_clk_div) | is_div_bypass;
    assign trig_edge = (is_trigger_on_rising_edge  &  trigger & ~prev_trigger) |
                       (is_trigger_on_falling_edge & ~trigger &  prev_trigger);
    assign accept    = trig_edge & (state == IDLE) & (loop_mode != 2'd0) & ~rst;
    assign restart   = (state == COMMIT) & (loop_mode == 2'd3);
    assign reload    = accept | restart;
    assign len_field = was_config[CAP_LENGTH_REGISTER*8 +: 6];

    // A length field of 0 wraps to 63 here, which is exactly the 64-sample case.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            prev_trigger <= 1'b0;
            prev_clk_div <= 1'b0;
            buffer       <= '0;
            remaining    <= '0;
        end else begin
            state        <= state_next;
            prev_trigger <= trigger;
            prev_clk_div <= clk_div;
            if (reload) begin
                buffer    <= '0;
                remaining <= len_field - 6'd1;
            end else if (state == CAPTURE && tick) begin
                buffer    <= {buffer[62:0], sig_in};
                remaining <= remaining - 6'd1;
            end
        end
    end

    always_comb begin
        state_next     = state;
        is_config      = was_config;
        is_update_flag = '0;
        is_running     = 1'b0;
        is_done        = 1'b0;

        case (state)
            IDLE:    if (accept) state_next = CAPTURE;
            CAPTURE: if (tick && remaining == 6'd0) state_next = COMMIT;
            COMMIT:  state_next = (loop_mode == 2'd3) ? CAPTURE : IDLE;
            default: state_next = IDLE;
        endcase

        // Bus writes are suppressed while reset is held so nothing partial reaches the bank.
        if (!rst) begin
            is_running = (state != IDLE);
            if (state == COMMIT) begin
                is_done = 1'b1;
                for (int k = 0; k < 8; k++) begin
                    is_config[(CAP_DATA_REGISTER + k)*8 +: 8] = buffer[k*8 +: 8];
                    is_update_flag[CAP_DATA_REGISTER + k]     = 1'b1;
                end
                is_config[CAP_COUNT_REGISTER*8 +: 8] = was_config[CAP_COUNT_REGISTER*8 +: 8] + 8'd1;
                is_update_flag[CAP_COUNT_REGISTER]   = 1'b1;
                if (loop_mode == 2'd1) begin
                    is_config[CAP_CONFIG_REGISTER*8 +: 8] = was_config[CAP_CONFIG_REGISTER*8 +: 8] & 8'hF3;
                end
                is_update_flag[CAP_CONFIG_REGISTER] = 1'b1;
            end
`ifdef SIGNAL_CAPTURE_TIMESTAMP_EN
            if (reload) begin
                for (int k = 0; k < 4; k++) begin
                    is_config[(CAP_TIMESTAMP_REGISTER + k)*8 +: 8] = counter[k*8 +: 8];
                    is_update_flag[CAP_TIMESTAMP_REGISTER + k]     = 1'b1;
                end
            end
`endif
        end
    end

`ifndef SIGNAL_CAPTURE_TIMESTAMP_EN
    logic unused_counter;
    assign unused_counter = ^counter;
`endif

endmodule
